// File: rtl/wbs_mailbox_pkg.sv
// wbs_mailbox_pkg: register map and bit positions shared by the mailbox RTL.
//   mbox_reg_e     : register select, encoded as the word index wbs_adr_i[3:2]
//                    (byte offsets 0x0/0x4/0x8/0xC).
//   ST_*           : STATUS register bit positions.
//   IRQEN_*        : IRQEN register bit positions.
package wbs_mailbox_pkg;

    typedef enum logic [1:0] {
        MBOX_TXDATA = 2'd0,
        MBOX_RXDATA = 2'd1,
        MBOX_STATUS = 2'd2,
        MBOX_IRQEN  = 2'd3
    } mbox_reg_e;

    localparam int unsigned ST_TX_FULL  = 0;
    localparam int unsigned ST_TX_EMPTY = 1;
    localparam int unsigned ST_RX_EMPTY = 2;
    localparam int unsigned ST_RX_FULL  = 3;
    localparam int unsigned ST_OVF      = 4;
    localparam int unsigned ST_UNF      = 5;
    localparam int unsigned ST_TX_COUNT = 8;
    localparam int unsigned ST_RX_COUNT = 16;

    localparam int unsigned IRQEN_RX_NE = 0;
    localparam int unsigned IRQEN_TX_E  = 1;

endpackage

// File: rtl/mbox_fifo.sv
// mbox_fifo: synchronous 32-bit FIFO with fall-through head.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   push_i, data_i  : write request and word (ignored when full)
//   pop_i           : read request (ignored when empty)
//   data_o          : current head word (valid while !empty_o)
//   full_o, empty_o : occupancy flags
//   count_o         : number of stored words
module mbox_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push_i,
    input  logic [31:0]   data_i,
    input  logic          pop_i,
    output logic [31:0]   data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Gating uses pre-edge flags, so a push to a full FIFO is dropped even
    // when a pop happens on the same edge.
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/wbs_mailbox.sv
// wbs_mailbox: Wishbone slave mailbox between the management bus and the core.
//   wb_clk_i, wb_rst_n_i       : clock, asynchronous active-low reset
//   wbs_cyc/stb/we/sel/adr/dat : Wishbone slave request
//   wbs_ack_o, wbs_dat_o       : registered acknowledge and read data
//   tx_valid_o/tx_data_o/tx_ready_i : TX FIFO head towards the core
//   rx_valid_i/rx_data_i/rx_ready_o : core words into the RX FIFO
//   irq_o                      : registered level interrupt
// Optional feature macro: WBS_MAILBOX_IRQ_EN (IRQEN register and irq_o logic).
module wbs_mailbox
    import wbs_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned CW        = $clog2(DEPTH) + 1
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        tx_valid_o,
    output logic [31:0] tx_data_o,
    input  logic        tx_ready_i,
    input  logic        rx_valid_i,
    input  logic [31:0] rx_data_i,
    output logic        rx_ready_o,
    output logic        irq_o
);
    logic          take, status_wr;
    logic          wb_tx_push, wb_rx_pop;
    mbox_reg_e     reg_sel;
    logic          tx_full, tx_empty, rx_full, rx_empty;
    logic [CW-1:0] tx_count, rx_count;
    logic [31:0]   rx_head, status_word;
    logic [1:0]    irqen_rd;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          unused_bits;

    assign unused_bits = ^{wbs_adr_i[1:0], wbs_sel_i[3:1]};

    // A request is taken only while no ack is outstanding, so a held strobe
    // is re-sampled on the edge after the ack (2 cycles per access).
    assign take = wbs_cyc_i & wbs_stb_i & ~ack_q
                & (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign reg_sel    = mbox_reg_e'(wbs_adr_i[3:2]);
    assign wb_tx_push = take & wbs_we_i & (reg_sel == MBOX_TXDATA);
    assign wb_rx_pop  = take & ~wbs_we_i & (reg_sel == MBOX_RXDATA);
    assign status_wr  = take & wbs_we_i & (reg_sel == MBOX_STATUS) & wbs_sel_i[0];

    assign tx_valid_o = ~tx_empty;
    assign rx_ready_o = ~rx_full;

    mbox_fifo #(.DEPTH(DEPTH), .CW(CW)) u_tx_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n_i),
        .push_i  (wb_tx_push),
        .data_i  (wbs_dat_i),
        .pop_i   (tx_ready_i),
        .data_o  (tx_data_o),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count)
    );

    mbox_fifo #(.DEPTH(DEPTH), .CW(CW)) u_rx_fifo (
        .clk_i   (wb_clk_i),
        .rst_ni  (wb_rst_n_i),
        .push_i  (rx_valid_i),
        .data_i  (rx_data_i),
        .pop_i   (wb_rx_pop),
        .data_o  (rx_head),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .count_o (rx_count)
    );

    always_comb begin
        status_word = '0;
        status_word[ST_TX_FULL]        = tx_full;
        status_word[ST_TX_EMPTY]       = tx_empty;
        status_word[ST_RX_EMPTY]       = rx_empty;
        status_word[ST_RX_FULL]        = rx_full;
        status_word[ST_OVF]            = ovf_q;
        status_word[ST_UNF]            = unf_q;
        status_word[ST_TX_COUNT +: CW] = tx_count;
        status_word[ST_RX_COUNT +: CW] = rx_count;
    end

    always_comb begin
        ack_d = take;
        dat_d = '0;
        if (take && !wbs_we_i) begin
            case (reg_sel)
                MBOX_RXDATA: dat_d = rx_empty ? '0 : rx_head;
                MBOX_STATUS: dat_d = status_word;
                MBOX_IRQEN:  dat_d = {30'd0, irqen_rd};
                default:     dat_d = '0;
            endcase
        end
        // Clear first so a simultaneous new event wins over W1C.
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (status_wr && wbs_dat_i[ST_OVF]) ovf_d = 1'b0;
        if (status_wr && wbs_dat_i[ST_UNF]) unf_d = 1'b0;
        if (wb_tx_push && tx_full)          ovf_d = 1'b1;
        if (wb_rx_pop && rx_empty)          unf_d = 1'b1;
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            ack_q <= 1'b0;
            dat_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ack_q <= ack_d;
            dat_q <= dat_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

`ifdef WBS_MAILBOX_IRQ_EN
    logic [1:0] irqen_q, irqen_d;
    logic       irq_q, irq_d;

    always_comb begin
        irqen_d = irqen_q;
        if (take && wbs_we_i && (reg_sel == MBOX_IRQEN) && wbs_sel_i[0])
            irqen_d = wbs_dat_i[1:0];
        irq_d = (irqen_q[IRQEN_RX_NE] & ~rx_empty)
              | (irqen_q[IRQEN_TX_E] & tx_empty);
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            irqen_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end

    assign irqen_rd = irqen_q;
    assign irq_o    = irq_q;
`else
    assign irqen_rd = '0;
    assign irq_o    = 1'b0;
`endif

endmodule

// File: tb/tb_wbs_mailbox.sv
// tb_wbs_mailbox: scoreboard bench for wbs_mailbox with a queue-based model.
module tb_wbs_mailbox;
    import wbs_mailbox_pkg::*;

    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          DEPTH = 4;

    logic        clk, rst_n;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, irq;
    logic [31:0] tx_data, rx_data;

    wbs_mailbox #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wbs_cyc_i  (cyc),
        .wbs_stb_i  (stb),
        .wbs_we_i   (we),
        .wbs_sel_i  (sel),
        .wbs_adr_i  (adr),
        .wbs_dat_i  (wdat),
        .wbs_ack_o  (ack),
        .wbs_dat_o  (rdat),
        .tx_valid_o (tx_valid),
        .tx_data_o  (tx_data),
        .tx_ready_i (tx_ready),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .rx_ready_o (rx_ready),
        .irq_o      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntotal++;
        if (act !== exp) $display("FAIL %s actual=%h expected=%h", name, act, exp);
        else npass++;
    endtask

    // Reference model: FIFOs as queues, flags as bits, expected read data queued.
    logic [31:0] txq[$];
    logic [31:0] rxq[$];
    logic [31:0] sbq[$];
    bit          ovf_m, unf_m, ack_m, irq_m;
    logic [1:0]  irqen_m;

    function automatic logic [31:0] status_m();
        logic [31:0] s;
        s = 32'(txq.size()) << 8 | 32'(rxq.size()) << 16;
        if (txq.size() == DEPTH) s = s | 32'h01;
        if (txq.size() == 0)     s = s | 32'h02;
        if (rxq.size() == 0)     s = s | 32'h04;
        if (rxq.size() == DEPTH) s = s | 32'h08;
        if (ovf_m)               s = s | 32'h10;
        if (unf_m)               s = s | 32'h20;
        return s;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        int          txn, rxn;
        bit          take, wpush, wpop, cpop, cpush, oset, uset, oclr, uclr, inext;
        logic [31:0] resp;
        if (!rst_n) begin
            txq.delete(); rxq.delete(); sbq.delete();
            ovf_m = 0; unf_m = 0; ack_m = 0; irq_m = 0; irqen_m = 2'b00;
        end else begin
            txn = txq.size(); rxn = rxq.size();
            wpush = 0; wpop = 0; oset = 0; uset = 0; oclr = 0; uclr = 0;
            inext = (irqen_m[0] && rxn > 0) || (irqen_m[1] && txn == 0);
            take = cyc && stb && !ack_m && (adr[31:4] == BASE[31:4]);
            if (take) begin
                resp = 32'h0;
                case (adr[3:2])
                    2'd0: if (we) begin
                        if (txn == DEPTH) oset = 1; else wpush = 1;
                    end
                    2'd1: if (!we) begin
                        if (rxn == 0) uset = 1;
                        else begin resp = rxq[0]; wpop = 1; end
                    end
                    2'd2: if (!we) resp = status_m();
                          else if (sel[0]) begin oclr = wdat[4]; uclr = wdat[5]; end
                    default: if (!we) resp = {30'd0, irqen_m};
`ifdef WBS_MAILBOX_IRQ_EN
                          else if (sel[0]) irqen_m = wdat[1:0];
`endif
                endcase
                sbq.push_back(resp);
            end
            cpop  = tx_ready && txn > 0;
            cpush = rx_valid && rxn < DEPTH;
            if (cpop)  void'(txq.pop_front());
            if (wpush) txq.push_back(wdat);
            if (wpop)  void'(rxq.pop_front());
            if (cpush) rxq.push_back(rx_data);
            if (oclr) ovf_m = 0;
            if (uclr) unf_m = 0;
            if (oset) ovf_m = 1;
            if (uset) unf_m = 1;
            ack_m = take;
            irq_m = inext;
        end
    end

    // Monitor: compares DUT outputs against the model on every falling edge.
    always @(negedge clk) begin
        logic [31:0] e;
        chk("ack", ack, ack_m);
        if (ack) begin
            chk("sb_nonempty", 32'(sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("rdata", rdat, e);
            end
        end else begin
            chk("dat_idle", rdat, 0);
        end
        chk("tx_valid", tx_valid, txq.size() != 0);
        if (txq.size() != 0) chk("tx_data", tx_data, txq[0]);
        chk("rx_ready", rx_ready, rxq.size() < DEPTH);
        chk("irq", irq, irq_m);
    end

    bit core_rand = 0;
    initial forever begin
        @(negedge clk);
        if (core_rand) begin
            tx_ready = ($urandom_range(0, 2) == 0);
            rx_valid = $urandom_range(0, 1) == 1;
            rx_data  = $urandom;
        end
    end

    task automatic wb_xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit exp_ack, output logic [31:0] rd);
        bit acked;
        int lat;
        @(negedge clk);
        cyc = 1; stb = 1; we = w; adr = a; wdat = d; sel = s;
        acked = 0; lat = 0; rd = 32'h0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (ack) begin acked = 1; lat = i; rd = rdat; break; end
        end
        @(negedge clk);
        cyc = 0; stb = 0; we = 0;
        if (exp_ack) begin
            chk("ack_seen", 32'(acked), 1);
            if (acked) chk("ack_latency", lat, 0);
        end else begin
            chk("no_ack_outside", 32'(acked), 0);
        end
    endtask

    function automatic logic [31:0] ra(input mbox_reg_e r);
        return BASE | (32'(r) << 2);
    endfunction

    logic [31:0] rd;

    initial begin
        rst_n = 0; cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = '0; wdat = '0;
        tx_ready = 0; rx_valid = 0; rx_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_dat", rdat, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_rx_ready", rx_ready, 1);
        chk("rst_irq", irq, 0);
        rst_n = 1;

        wb_xfer(0, ra(MBOX_STATUS), 0, 4'hF, 1, rd);
        chk("status_reset", rd, 32'h0000_0006);

        wb_xfer(1, ra(MBOX_TXDATA), 32'hDEAD_BEEF, 4'h0, 1, rd);
        chk("tx_valid_after_wr", tx_valid, 1);
        chk("tx_data_after_wr", tx_data, 32'hDEAD_BEEF);
        tx_ready = 1;
        @(negedge clk);
        chk("tx_valid_after_pop", tx_valid, 0);
        tx_ready = 0;

        for (int i = 0; i < 5; i++) wb_xfer(1, ra(MBOX_TXDATA), 32'hA000_0000 + 32'(i), 4'hF, 1, rd);
        wb_xfer(0, ra(MBOX_STATUS), 0, 4'hF, 1, rd);
        chk("status_tx_full_ovf", rd, 32'h0000_0415);
        wb_xfer(1, ra(MBOX_STATUS), 32'h10, 4'hF, 1, rd);
        wb_xfer(0, ra(MBOX_STATUS), 0, 4'hF, 1, rd);
        chk("status_ovf_cleared", rd, 32'h0000_0405);
        tx_ready = 1;
        repeat (5) @(negedge clk);
        tx_ready = 0;

`ifdef WBS_MAILBOX_IRQ_EN
        wb_xfer(1, ra(MBOX_IRQEN), 32'h1, 4'h1, 1, rd);
`endif
        rx_valid = 1; rx_data = 32'h1234_5678;
        @(negedge clk);
        rx_valid = 0;
        @(negedge clk);
`ifdef WBS_MAILBOX_IRQ_EN
        chk("irq_rx_ne", irq, 1);
`else
        chk("irq_tied_low", irq, 0);
`endif
        wb_xfer(0, ra(MBOX_RXDATA), 0, 4'hF, 1, rd);
        chk("rxdata_word", rd, 32'h1234_5678);
        @(negedge clk);
        chk("irq_after_pop", irq, 0);
`ifdef WBS_MAILBOX_IRQ_EN
        wb_xfer(1, ra(MBOX_IRQEN), 32'h0, 4'h1, 1, rd);
`endif

        wb_xfer(0, ra(MBOX_RXDATA), 0, 4'hF, 1, rd);
        chk("rxdata_empty", rd, 32'h0);
        wb_xfer(0, ra(MBOX_STATUS), 0, 4'hF, 1, rd);
        chk("status_unf", rd, 32'h0000_0026);
        wb_xfer(1, ra(MBOX_STATUS), 32'h20, 4'hE, 1, rd);
        wb_xfer(0, ra(MBOX_STATUS), 0, 4'hF, 1, rd);
        chk("w1c_needs_sel0", rd, 32'h0000_0026);
        wb_xfer(1, ra(MBOX_STATUS), 32'h20, 4'h1, 1, rd);
        wb_xfer(0, ra(MBOX_STATUS), 0, 4'hF, 1, rd);
        chk("status_unf_cleared", rd, 32'h0000_0006);

        wb_xfer(0, BASE + 32'h10, 0, 4'hF, 0, rd);

        // Reset in the middle of an access with both FIFOs partly filled.
        wb_xfer(1, ra(MBOX_TXDATA), 32'h1111_1111, 4'hF, 1, rd);
        wb_xfer(1, ra(MBOX_TXDATA), 32'h2222_2222, 4'hF, 1, rd);
        rx_valid = 1; rx_data = 32'h3333_3333;
        @(negedge clk);
        rx_valid = 0;
        @(negedge clk);
        cyc = 1; stb = 1; we = 0; adr = ra(MBOX_RXDATA); sel = 4'hF;
        #2 rst_n = 0;
        #1;
        chk("midrst_ack", ack, 0);
        chk("midrst_dat", rdat, 0);
        chk("midrst_tx_valid", tx_valid, 0);
        chk("midrst_rx_ready", rx_ready, 1);
        chk("midrst_irq", irq, 0);
        cyc = 0; stb = 0;
        @(negedge clk);
        rst_n = 1;
        wb_xfer(0, ra(MBOX_STATUS), 0, 4'hF, 1, rd);
        chk("status_after_rst", rd, 32'h0000_0006);

        core_rand = 1;
        for (int n = 0; n < 300; n++) begin
            wb_xfer($urandom_range(0, 1) == 1,
                    BASE | 32'($urandom_range(0, 15)),
                    $urandom, 4'($urandom_range(0, 15)), 1, rd);
        end
        core_rand = 0;
        tx_ready = 0; rx_valid = 0;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/wbs_mailbox.md
# wbs_mailbox

Wishbone slave mailbox between the Caravel management-side `wbs_*` bus and the j202 SoC core. It provides two word FIFOs: TX carries management-to-core words and RX carries core-to-management words. It also provides a sticky status register and an interrupt source routed onto `user_irq`. The block sits inside the user project area, directly downstream of the wrapper's Wishbone pins and upstream of the core's mailbox port.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000: mailbox window base; `wbs_adr_i[31:4]` must equal `BASE_ADDR[31:4]`.
- `DEPTH`, 4: entries per FIFO; power of two, ≥2.
- `CW`, $clog2(DEPTH)+1: occupancy count width.

Ports (clock and reset first):
- `wb_clk_i` in 1: single clock; one clock domain.
- `wb_rst_n_i` in 1: reset, asynchronous assert, active-low.
- `wbs_cyc_i` in 1: Wishbone cycle.
- `wbs_stb_i` in 1: Wishbone strobe.
- `wbs_we_i` in 1: write enable.
- `wbs_sel_i` in 4: byte enables.
- `wbs_adr_i` in 32: byte address.
- `wbs_dat_i` in 32: write data.
- `wbs_ack_o` out 1: acknowledge, registered.
- `wbs_dat_o` out 32: read data, registered.
- `tx_valid_o` out 1: TX FIFO head valid, to core.
- `tx_data_o` out 32: TX FIFO head word.
- `tx_ready_i` in 1: core accepts TX head.
- `rx_valid_i` in 1: core offers a word.
- `rx_data_i` in 32: core word.
- `rx_ready_o` out 1: RX FIFO can accept.
- `irq_o` out 1: level interrupt, registered.

## Operation
Registers are selected by `adr[3:2]`:
- 0x0 TXDATA (W): pushes `wbs_dat_i` into TX; `sel` is ignored. If TX is full, the word is dropped, OVF is set and the access is still acked. A read returns 0.
- 0x4 RXDATA (R): pops the RX head and returns it. If RX is empty, it returns 0 and sets UNF. A write is acked with no effect.
- 0x8 STATUS: [0] tx_full, [1] tx_empty, [2] rx_empty, [3] rx_full, [4] OVF, [5] UNF, [8+:CW] tx_count, [16+:CW] rx_count. A write of 1 to bit 4 or bit 5 clears that bit (W1C); honoured only when `sel[0]`=1.
- 0xC IRQEN (RW, bits [1:0]): [0] enables the RX-not-empty interrupt, [1] enables the TX-empty interrupt. Written only when `sel[0]`=1. Unused bits read 0.

Addresses outside the window are never acked; the other slave owns them.

Core side:
- `tx_valid_o` = !tx_empty, and `tx_data_o` shows the head (fall-through). TX pops on `tx_valid_o & tx_ready_i`.
- `rx_ready_o` = !rx_full. RX pushes on `rx_valid_i & rx_ready_o`.

`irq_o` is registered: (IRQEN[0] & !rx_empty) | (IRQEN[1] & tx_empty).

## Timing
- Reset values: `wbs_ack_o`=0, `wbs_dat_o`=0, both FIFOs empty, OVF=UNF=0, IRQEN=0, `irq_o`=0, `tx_valid_o`=0, `rx_ready_o`=1.
- Reset may assert mid-access: any pending access is dropped, and the master must restart the cycle.
- Ack: the decoded request (`cyc & stb` and address match) is sampled at edge N while `wbs_ack_o`=0. `wbs_ack_o`=1 for exactly one cycle after edge N. Side effects (push, pop, W1C, IRQEN write) commit at edge N. `wbs_dat_o` is valid with the ack and 0 otherwise.
- A back-to-back request still held after the ack is re-sampled on the next edge, giving a minimum 2 cycles per access.
- Full and empty are evaluated on pre-edge state:
  - A WB push to a full TX in the same cycle as a core pop is dropped (OVF=1).
  - A WB read of an empty RX in the same cycle as a core push returns 0 (UNF=1); the core word is kept.
- A push and pop on the same edge leave the count unchanged.
- FIFO pointers wrap modulo DEPTH, and the count saturates at neither bound because pushes and pops are gated.
- A W1C in the same edge as a new OVF/UNF event: set wins.
- `irq_o` follows a state change with 1-cycle latency.

## Configuration
- `WBS_MAILBOX_IRQ_EN` defined: IRQEN register and the `irq_o` logic are present as described.
- Not defined: `irq_o` is tied 0, and IRQEN reads 0 and ignores writes. All other behaviour is unchanged.

## Structure
- Shared package `wbs_mailbox_pkg` holds:
  - register offset constants `MBOX_TXDATA`, `MBOX_RXDATA`, `MBOX_STATUS`, `MBOX_IRQEN`;
  - STATUS bit-index constants;
  - the IRQEN bit indices.
- Sub-module `mbox_fifo`: synchronous FIFO with DEPTH and width 32, fall-through head, and full/empty/count outputs. It is instantiated twice (TX, RX).
- Wishbone decode, ack register, sticky flags and IRQ live in the top.

## Test plan
- Reset, then read STATUS → 0x0000_0006 (tx_empty, rx_empty), with ack exactly 1 cycle after the strobe is sampled.
- Write TXDATA 0xDEAD_BEEF with `tx_ready_i`=0 → next cycle `tx_valid_o`=1 and `tx_data_o`=0xDEAD_BEEF; raise `tx_ready_i` → `tx_valid_o`=0 one cycle later.
- Five TXDATA writes (DEPTH=4) with the core stalled → STATUS shows tx_full, OVF=1, tx_count=4. Write STATUS 0x10 → OVF=0.
- Core pushes 0x1234_5678; IRQEN=1 (macro defined) → `irq_o`=1. Read RXDATA → 0x1234_5678, then `irq_o`=0 and rx_empty=1.
- Read RXDATA when empty → data 0, UNF=1. A read at an address outside the window, `BASE_ADDR`+0x10, → no ack within 8 cycles.
- Assert `wb_rst_n_i` low mid-access with both FIFOs partially full → all outputs immediately at their reset values and counts 0.
